zbuffer_pixel_writer: RTL and testbench



---
 rtl/zbuffer_pixel_writer_pkg.sv | 25 ++
 rtl/zbuf_hazard_tracker.sv | 41 ++++
 rtl/zbuffer_pixel_writer.sv | 147 ++++++++++++++
 tb/tb_zbuffer_pixel_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/zbuffer_pixel_writer_pkg.sv
// Shared types and constants for the depth-tested pixel writer.
package zbuffer_pixel_writer_pkg;

  localparam int ZB_ADDR_BITS  = 18;
  localparam int ZB_COLOR_BITS = 16;
  localparam int ZB_DEPTH_BITS = 16;

  localparam logic [ZB_DEPTH_BITS-1:0] CLEAR_DEPTH_FP16 = 16'h7C00;

  typedef logic [ZB_ADDR_BITS-1:0] zbuf_addr_t;

  typedef struct packed {
    logic [15:0]              hcount;
    logic [15:0]              vcount;
    logic [ZB_COLOR_BITS-1:0] color;
    logic [ZB_DEPTH_BITS-1:0] depth;
  } zb_fragment_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN
  } zb_state_t;

endpackage

// File: rtl/zbuf_hazard_tracker.sv
// Tracks addresses of fragments accepted 1..STAGES cycles ago so a new read
// of the same pixel waits until the pending depth write has landed.
module zbuf_hazard_tracker
  import zbuffer_pixel_writer_pkg::*;
#(
  parameter int ADDR_BITS = ZB_ADDR_BITS,
  parameter int STAGES    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push_valid,
  input  logic [ADDR_BITS-1:0] push_addr,
  input  logic [ADDR_BITS-1:0] probe_addr,
  output logic                 match
);

  logic [STAGES-1:0]    valid;
  logic [ADDR_BITS-1:0] addr [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < STAGES; i++) addr[i] <= '0;
    end else begin
      valid[0] <= push_valid & ~flush;
      addr[0]  <= push_addr;
      for (int i = 1; i < STAGES; i++) begin
        valid[i] <= valid[i-1] & ~flush;
        addr[i]  <= addr[i-1];
      end
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < STAGES; i++)
      if (valid[i] && (addr[i] == probe_addr)) match = 1'b1;
  end

endmodule

// File: rtl/zbuffer_pixel_writer.sv
// Depth-tested pixel writer: clears pixel/depth BRAMs at frame start, then
// reads stored depth per fragment and writes colour+depth when nearer.
module zbuffer_pixel_writer
  import zbuffer_pixel_writer_pkg::*;
#(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int ADDR_BITS    = ZB_ADDR_BITS,
  parameter int COLOR_WIDTH  = ZB_COLOR_BITS,
  parameter int DEPTH_WIDTH  = ZB_DEPTH_BITS,
  parameter int RD_LATENCY   = 2,
  parameter logic [DEPTH_WIDTH-1:0] CLEAR_DEPTH = CLEAR_DEPTH_FP16,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_hcount,
  input  logic [15:0]            in_vcount,
  input  logic                   in_within,
  input  logic [COLOR_WIDTH-1:0] in_color,
  input  logic [DEPTH_WIDTH-1:0] in_depth,
  output logic [ADDR_BITS-1:0]   zb_raddr,
  input  logic [DEPTH_WIDTH-1:0] zb_rdata,
  output logic                   zb_we,
  output logic [ADDR_BITS-1:0]   zb_waddr,
  output logic [DEPTH_WIDTH-1:0] zb_wdata,
  output logic                   pix_we,
  output logic [ADDR_BITS-1:0]   pix_addr,
  output logic [COLOR_WIDTH-1:0] pix_wdata,
  output logic                   clearing,
  output logic                   clear_done
);

  localparam int LOG2_W = $clog2(FRAME_WIDTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  zb_state_t            state, state_next;
  logic [ADDR_BITS-1:0] clr_addr;
  zb_fragment_t         frag;
  logic [ADDR_BITS-1:0] frag_addr;
  logic                 in_frame, hazard, accept, keep, pass, frag_we;

  logic [RD_LATENCY:1]  s_valid;
  logic [ADDR_BITS-1:0] s_addr [1:RD_LATENCY];
  zb_fragment_t         s_frag [1:RD_LATENCY];
  logic                 w_valid;
  logic [ADDR_BITS-1:0] w_addr;
  zb_fragment_t         w_frag;

  always_comb frag = '{hcount: in_hcount, vcount: in_vcount, color: in_color, depth: in_depth};

  assign frag_addr = (ADDR_BITS'(frag.vcount) << LOG2_W) + ADDR_BITS'(frag.hcount);
  assign in_frame  = in_within && (frag.hcount < 16'(FRAME_WIDTH)) && (frag.vcount < 16'(FRAME_HEIGHT));
  // Off-frame/uncovered fragments never read or write, so they never stall.
  assign in_ready  = (state == ST_RUN) && !(hazard && in_frame);
  assign accept    = in_valid && in_ready;
  assign keep      = accept && in_frame;
  assign zb_raddr  = keep ? frag_addr : '0;
  assign pass      = s_valid[RD_LATENCY] && (s_frag[RD_LATENCY].depth < zb_rdata);

  zbuf_hazard_tracker #(
    .ADDR_BITS (ADDR_BITS),
    .STAGES    (RD_LATENCY + 1)
  ) u_hazard (
    .clk        (clk),
    .rst        (rst),
    .flush      (frame_start),
    .push_valid (keep),
    .push_addr  (frag_addr),
    .probe_addr (frag_addr),
    .match      (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= '0;
      w_valid <= 1'b0;
      w_addr  <= '0;
      w_frag  <= '0;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        s_addr[i] <= '0;
        s_frag[i] <= '0;
      end
    end else begin
      s_valid[1] <= keep & ~frame_start;
      s_addr[1]  <= frag_addr;
      s_frag[1]  <= frag;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        s_valid[i] <= s_valid[i-1] & ~frame_start;
        s_addr[i]  <= s_addr[i-1];
        s_frag[i]  <= s_frag[i-1];
      end
      w_valid <= pass & ~frame_start;
      if (pass) begin
        w_addr <= s_addr[RD_LATENCY];
        w_frag <= s_frag[RD_LATENCY];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_addr   <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      clear_done <= (state == ST_CLEAR) && (clr_addr == LAST_ADDR) && !frame_start;
      if (frame_start || (state != ST_CLEAR) || (clr_addr == LAST_ADDR)) clr_addr <= '0;
      else clr_addr <= clr_addr + 1'b1;
    end
  end

  // A write already in its output cycle is still dropped by frame_start.
  assign frag_we = w_valid && !frame_start;

  always_comb begin
    state_next = state;
    clearing   = 1'b0;
    zb_we      = frag_we;
    pix_we     = frag_we;
    zb_waddr   = w_addr;
    pix_addr   = w_addr;
    zb_wdata   = w_frag.depth;
    pix_wdata  = w_frag.color;
    case (state)
      ST_IDLE: if (frame_start) state_next = ST_CLEAR;
      ST_CLEAR: begin
        clearing  = 1'b1;
        zb_we     = 1'b1;
        pix_we    = 1'b1;
        zb_waddr  = clr_addr;
        pix_addr  = clr_addr;
        zb_wdata  = CLEAR_DEPTH;
        pix_wdata = CLEAR_COLOR;
        if (frame_start) state_next = ST_CLEAR;
        else if (clr_addr == LAST_ADDR) state_next = ST_RUN;
      end
      ST_RUN: if (frame_start) state_next = ST_CLEAR;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_zbuffer_pixel_writer.sv
// Directed bench for zbuffer_pixel_writer on a 16x8 frame with behavioural
// depth/pixel BRAMs (2-cycle read latency, read-before-write).
module tb_zbuffer_pixel_writer;

  localparam int FW = 16;
  localparam int FH = 8;

  logic        clk, rst, frame_start, in_valid, in_ready, in_within;
  logic [15:0] in_hcount, in_vcount, in_color, in_depth;
  logic [17:0] zb_raddr, zb_waddr, pix_addr;
  logic [15:0] zb_rdata, zb_wdata, pix_wdata;
  logic        zb_we, pix_we, clearing, clear_done;

  zbuffer_pixel_writer #(
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .RD_LATENCY   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_hcount   (in_hcount),
    .in_vcount   (in_vcount),
    .in_within   (in_within),
    .in_color    (in_color),
    .in_depth    (in_depth),
    .zb_raddr    (zb_raddr),
    .zb_rdata    (zb_rdata),
    .zb_we       (zb_we),
    .zb_waddr    (zb_waddr),
    .zb_wdata    (zb_wdata),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_wdata   (pix_wdata),
    .clearing    (clearing),
    .clear_done  (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] zb_mem  [0:255];
  logic [15:0] pix_mem [0:255];
  logic [15:0] rd1, rd2;

  always @(posedge clk) begin
    rd1 <= zb_mem[zb_raddr[7:0]];
    rd2 <= rd1;
    if (zb_we)  zb_mem[zb_waddr[7:0]] <= zb_wdata;
    if (pix_we) pix_mem[pix_addr[7:0]] <= pix_wdata;
  end
  assign zb_rdata = rd2;

  int          cyc = 0;
  int          n_wr = 0;
  int          wr_cyc = 0;
  logic [17:0] wr_addr, wr_zaddr;
  logic [15:0] wr_col, wr_zdata;
  logic        wr_zwe;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pix_we && !clearing) begin
      n_wr     <= n_wr + 1;
      wr_cyc   <= cyc;
      wr_addr  <= pix_addr;
      wr_col   <= pix_wdata;
      wr_zwe   <= zb_we;
      wr_zaddr <= zb_waddr;
      wr_zdata <= zb_wdata;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int          stalls, acc_cyc;
  logic [17:0] acc_raddr;

  task automatic send(input logic [15:0] h, input logic [15:0] v, input logic w,
                      input logic [15:0] c, input logic [15:0] d);
    in_valid = 1'b1; in_hcount = h; in_vcount = v; in_within = w; in_color = c; in_depth = d;
    stalls = 0;
    #1;
    while (!in_ready && stalls < 20) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (!in_ready) check("accept_timeout", 80'(in_ready), 80'(1));
    acc_raddr = zb_raddr;
    acc_cyc   = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  int base, total, k;

  initial begin
    rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_within = 1'b0;
    in_hcount = '0; in_vcount = '0; in_color = '0; in_depth = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl", 80'({zb_we, pix_we, clearing, clear_done, in_ready}), 80'(0));
    check("rst_addr", 80'({zb_waddr, pix_addr, zb_raddr, zb_wdata, pix_wdata}), 80'(0));
    @(negedge clk); rst = 1'b0;
    in_valid = 1'b1; in_within = 1'b1; in_hcount = 16'd1; in_vcount = 16'd1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_ready", 80'({in_ready, clearing, zb_we}), 80'(0));
    in_valid = 1'b0;

    // full clear
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < FW * FH; i++) begin
      #1;
      check("clear", 80'({clearing, zb_we, pix_we, zb_waddr, pix_addr, zb_wdata, pix_wdata}),
            80'({1'b1, 1'b1, 1'b1, 18'(i), 18'(i), 16'h7C00, 16'h0000}));
      @(negedge clk);
    end
    #1;
    check("clear_end", 80'({clearing, clear_done, in_ready, zb_we, pix_we}), 80'(5'b01100));
    @(negedge clk); #1;
    check("done_pulse", 80'(clear_done), 80'(0));
    @(negedge clk);

    // single fragment (10,3) -> 3*16+10 = 58
    base = n_wr;
    send(16'd10, 16'd3, 1'b1, 16'h0F00, 16'h4000);
    check("t2_raddr", 80'(acc_raddr), 80'(58));
    repeat (4) @(negedge clk);
    check("t2_nwr", 80'(n_wr - base), 80'(1));
    check("t2_lat", 80'(wr_cyc - acc_cyc), 80'(3));
    check("t2_pix", 80'({wr_addr, wr_col}), 80'({18'd58, 16'h0F00}));
    check("t2_zb", 80'({wr_zwe, wr_zaddr, wr_zdata}), 80'({1'b1, 18'd58, 16'h4000}));

    // depth test at (5,5) -> 85
    base = n_wr;
    send(16'd5, 16'd5, 1'b1, 16'h1111, 16'h4400);
    send(16'd5, 16'd5, 1'b1, 16'h2222, 16'h4000);
    send(16'd5, 16'd5, 1'b1, 16'h3333, 16'h4200);
    send(16'd5, 16'd5, 1'b1, 16'h4444, 16'h4000);
    check("t3_stall", 80'(stalls), 80'(3));
    repeat (6) @(negedge clk);
    check("t3_nwr", 80'(n_wr - base), 80'(2));
    check("t3_zb", 80'(zb_mem[85]), 80'(16'h4000));
    check("t3_pix", 80'(pix_mem[85]), 80'(16'h2222));

    // hazard at (4,6) -> 100; second must see the first's depth 3000
    base = n_wr;
    send(16'd4, 16'd6, 1'b1, 16'hAAAA, 16'h3000);
    send(16'd4, 16'd6, 1'b1, 16'hBBBB, 16'h3800);
    check("t4_stall", 80'(stalls), 80'(3));
    repeat (6) @(negedge clk);
    check("t4_nwr", 80'(n_wr - base), 80'(1));
    check("t4_zb", 80'(zb_mem[100]), 80'(16'h3000));
    check("t4_pix", 80'(pix_mem[100]), 80'(16'hAAAA));

    // drops and full-rate stream
    base = n_wr;
    total = 0;
    send(16'd16, 16'd0, 1'b1, 16'hDEAD, 16'h0001);
    total += stalls;
    send(16'd1, 16'd1, 1'b0, 16'hDEAD, 16'h0001);
    total += stalls;
    send(16'd0, 16'd8, 1'b1, 16'hDEAD, 16'h0001);
    total += stalls;
    for (int i = 0; i < 4; i++) begin
      send(16'(i), 16'd0, 1'b1, 16'hC000 | 16'(i), 16'h1000);
      total += stalls;
    end
    send(16'd3, 16'd0, 1'b0, 16'hDEAD, 16'h0001);
    total += stalls;
    check("t5_rate", 80'(total), 80'(0));
    repeat (6) @(negedge clk);
    check("t5_nwr", 80'(n_wr - base), 80'(4));
    check("t5_alias", 80'({zb_mem[16], zb_mem[17]}), 80'({16'h7C00, 16'h7C00}));
    check("t5_pix3", 80'({pix_mem[3], zb_mem[3]}), 80'({16'hC003, 16'h1000}));

    // frame_start with three fragments in flight
    base = n_wr;
    send(16'd0, 16'd2, 1'b1, 16'h5555, 16'h1000);
    send(16'd1, 16'd2, 1'b1, 16'h5555, 16'h1000);
    send(16'd2, 16'd2, 1'b1, 16'h5555, 16'h1000);
    frame_start = 1'b1;
    #1;
    check("t6_suppress", 80'({pix_we, zb_we}), 80'(0));
    @(negedge clk); frame_start = 1'b0;
    #1;
    check("t6_clr0", 80'({clearing, pix_addr, pix_wdata}), 80'({1'b1, 18'd0, 16'h0000}));
    k = 0;
    while (pix_addr != 18'd50 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check("t6_reach", 80'(pix_addr), 80'(50));
    check("t6_nowr", 80'(n_wr - base), 80'(0));
    rst = 1'b1;
    #1;
    check("t6_rst", 80'({zb_we, pix_we, clearing, in_ready, clear_done}), 80'(0));
    check("t6_rst_addr", 80'({zb_waddr, pix_addr}), 80'(0));
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t6_idle", 80'({clearing, zb_we, in_ready}), 80'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
